// File: rtl/clk_divider_pkg.sv
// Shared constants and helpers for the clock divider slice.
// Holds the legal range for the divider width. The width itself
// remains a module parameter.
package clk_divider_pkg;

  localparam int NBITS_MIN = 1;
  localparam int NBITS_MAX = 16;

  // True when a requested counter width can be built by the divider.
  function automatic bit nbitsInRange(input int nbits);
    return (nbits >= NBITS_MIN) && (nbits <= NBITS_MAX);
  endfunction

endpackage

// File: rtl/clk_divider_cnt.sv
// Free-running NBITS-bit wrap counter for the clock divider.
// The counter wraps from all-ones back to zero with no dead cycle.
// tc_o looks one step ahead: it is high in the cycle just before
// the count reaches its terminal (all-ones) value. A flop fed from
// tc_o therefore rises exactly while the count sits at terminal.
module clk_divider_cnt #(
  parameter int NBITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [NBITS-1:0] count_o,
  output logic             tc_o
);

  // One below the terminal count. This is ~1, which is all ones
  // with bit 0 cleared, and it collapses to 0 when NBITS is 1.
  localparam logic [NBITS-1:0] PRE_TERMINAL = ~NBITS'(1);

  logic [NBITS-1:0] count_q;
  logic [NBITS-1:0] count_d;

  // Next count is a plain increment. Natural overflow gives the wrap.
  always_comb begin
    count_d = count_q + NBITS'(1);
  end

  // Count register. Synchronous active-low reset restarts at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == PRE_TERMINAL);

endmodule

// File: rtl/clk_divider.sv
// Divides i_clk by 2^NBITS.
// o_clk is a 50% duty clock taken from the counter MSB.
// o_tick pulses in the last input cycle of each output period.
// o_count exposes the running count.
// Every output comes straight from a flop. o_clk and o_tick are
// registered from the next count value, so they line up with o_count
// on the same edge.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_clk,
  output logic             o_tick,
  output logic [NBITS-1:0] o_count
);

  // Refuse widths the divider cannot build.
  if (!nbitsInRange(NBITS)) begin : gen_bad_nbits
    $fatal(1, "clk_divider: NBITS=%0d is outside the supported range 1..16", NBITS);
  end

  logic [NBITS-1:0] count;
  logic             preTerminal;
  logic [NBITS-1:0] countNext;
  logic             clk_q;
  logic             clk_d;
  logic             tick_q;
  logic             tick_d;

  clk_divider_cnt #(
    .NBITS(NBITS)
  ) u_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst),
    .count_o(count),
    .tc_o   (preTerminal)
  );

  // Precompute what the output flops must hold after the next edge.
  always_comb begin
    countNext = count + NBITS'(1);
    clk_d     = countNext[NBITS-1];
    tick_d    = preTerminal;
  end

  // Output flops. Reset forces a quiet low state that matches count 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign o_clk   = clk_q;
  assign o_tick  = tick_q;
  assign o_count = count;

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider at NBITS = 3, 1 and 4.
// The three instances share one clock and have separate resets.
// Outputs are sampled 1 time unit after each rising edge.
module tb_clk_divider;

  logic       clk = 1'b0;
  logic       rst3;
  logic       rst1;
  logic       rst4;
  logic       oClk3;
  logic       oTick3;
  logic [2:0] oCount3;
  logic       oClk1;
  logic       oTick1;
  logic [0:0] oCount1;
  logic       oClk4;
  logic       oTick4;
  logic [3:0] oCount4;

  int checkCount = 0;
  int passCount  = 0;

  // Free-running input clock with a period of 10 time units.
  always #5 clk = ~clk;

  clk_divider #(.NBITS(3)) dut3 (
    .i_clk  (clk),
    .i_rst  (rst3),
    .o_clk  (oClk3),
    .o_tick (oTick3),
    .o_count(oCount3)
  );

  clk_divider #(.NBITS(1)) dut1 (
    .i_clk  (clk),
    .i_rst  (rst1),
    .o_clk  (oClk1),
    .o_tick (oTick1),
    .o_count(oCount1)
  );

  clk_divider #(.NBITS(4)) dut4 (
    .i_clk  (clk),
    .i_rst  (rst4),
    .o_clk  (oClk4),
    .o_tick (oTick4),
    .o_count(oCount4)
  );

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive the three reset levels, then advance one edge and settle.
  task automatic applyStimulus(input logic nRst3, input logic nRst1, input logic nRst4);
    rst3 = nRst3;
    rst1 = nRst1;
    rst4 = nRst4;
    @(posedge clk);
    #1;
  endtask

  // Safety net so a stuck run still ends with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, %0d/%0d checks passed",
             passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    bit clkPat3 [8];
    int expCnt;
    int prevClk;
    int lastRise;
    int firstRise;
    int highCnt;
    int tickCnt;
    int periods;

    clkPat3 = '{0, 0, 0, 0, 1, 1, 1, 1};

    // Hold every instance in reset for two edges.
    for (int e = 0; e < 2; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rst3 count", 32'(oCount3), 32'd0);
      checkOutput("rst3 clk",   32'(oClk3),   32'd0);
      checkOutput("rst3 tick",  32'(oTick3),  32'd0);
    end
    checkOutput("rst1 clk",  32'(oClk1),  32'd0);
    checkOutput("rst4 tick", 32'(oTick4), 32'd0);

    // NBITS=3 free run for 32 edges, i.e. four full periods.
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      expCnt = k % 8;
      checkOutput($sformatf("run3 count e%0d", k), 32'(oCount3), 32'(expCnt));
      checkOutput($sformatf("run3 clk e%0d", k),   32'(oClk3),   32'(clkPat3[expCnt]));
      checkOutput($sformatf("run3 tick e%0d", k),  32'(oTick3),  32'(expCnt == 7));
    end

    // Advance to count 5, then reset in the middle of the period.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("mid3 pre count", 32'(oCount3), 32'd5);
    checkOutput("mid3 pre clk",   32'(oClk3),   32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid3 rst count", 32'(oCount3), 32'd0);
    checkOutput("mid3 rst clk",   32'(oClk3),   32'd0);
    checkOutput("mid3 rst tick",  32'(oTick3),  32'd0);
    // After release, o_clk rises on the fourth edge.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("mid3 count e%0d", k), 32'(oCount3), 32'(k));
      checkOutput($sformatf("mid3 clk e%0d", k),   32'(oClk3),   32'(k == 4));
    end

    // Hold NBITS=3 in reset for a long stretch. Nothing may move.
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("hold3 count e%0d", k), 32'(oCount3), 32'd0);
      checkOutput($sformatf("hold3 clk e%0d", k),   32'(oClk3),   32'd0);
      checkOutput($sformatf("hold3 tick e%0d", k),  32'(oTick3),  32'd0);
    end

    // NBITS=1 divides by two, and the tick tracks the output clock.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("run1 clk e%0d", k),   32'(oClk1),   32'(k % 2));
      checkOutput($sformatf("run1 tick e%0d", k),  32'(oTick1),  32'(k % 2));
      checkOutput($sformatf("run1 count e%0d", k), 32'(oCount1), 32'(k % 2));
    end

    // NBITS=4: measure ten output periods between o_clk rising edges.
    // The first rise is expected on the 8th edge, so 168 edges cover
    // eleven rises. A couple of spare edges are added.
    prevClk   = 0;
    lastRise  = -1;
    firstRise = -1;
    highCnt   = 0;
    tickCnt   = 0;
    periods   = 0;
    for (int e = 1; e <= 170; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (e == 15) begin
        checkOutput("run4 count e15", 32'(oCount4), 32'd15);
        checkOutput("run4 tick e15",  32'(oTick4),  32'd1);
      end
      if (e == 16) begin
        checkOutput("run4 count e16", 32'(oCount4), 32'd0);
        checkOutput("run4 tick e16",  32'(oTick4),  32'd0);
      end
      if ((oClk4 === 1'b1) && (prevClk == 0)) begin
        if (lastRise >= 0) begin
          checkOutput($sformatf("run4 period p%0d", periods), 32'(e - lastRise), 32'd16);
          checkOutput($sformatf("run4 high p%0d", periods),   32'(highCnt),      32'd8);
          checkOutput($sformatf("run4 ticks p%0d", periods),  32'(tickCnt),      32'd1);
          periods++;
        end else begin
          firstRise = e;
        end
        lastRise = e;
        highCnt  = 0;
        tickCnt  = 0;
      end
      if (oClk4 === 1'b1) highCnt++;
      if (oTick4 === 1'b1) tickCnt++;
      prevClk = (oClk4 === 1'b1) ? 1 : 0;
    end
    checkOutput("run4 first rise", 32'(firstRise), 32'd8);
    checkOutput("run4 periods",    32'(periods),   32'd10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
